sfu_acc_bank: RTL and testbench

SFU_ACC_BANK -- requirements
Module: sfu_acc_bank

---
 rtl/sfu_acc_bank.sv | 154 +++++++++++++++
 tb/tb_sfu_acc_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sfu_acc_bank.sv
// rtl/sfu_acc_bank.sv - saturating accumulator bank with streamed, clamped drain
//
// Purpose: NUM_LINES signed accumulators. In IDLE each accepted psum either
// adds into (acc=1, saturating at ACC_BW) or overwrites (acc=0) the entry
// picked by selLine. drain_start streams every entry out in index order,
// clamped to PSUM_BW with optional ReLU, clearing each entry as it is taken.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   psum_in/psum_valid/selLine/acc -> psum_ready   accumulate input handshake
//   drain_start, relu          drain request, ReLU applied to drained data
//   out_data/out_idx/out_valid <- out_ready        drain beat handshake
//   drain_done                 one-cycle pulse after the last beat
//   ovf_flag                   sticky accumulator saturation indicator
module sfu_acc_bank #(
  parameter int PSUM_BW   = 16,
  parameter int NUM_LINES = 16,
  parameter int SEL_BW    = 4,
  parameter int ACC_BW    = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [PSUM_BW-1:0] psum_in,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [SEL_BW-1:0]         selLine,
  input  logic                      acc,
  input  logic                      relu,
  input  logic                      drain_start,
  output logic signed [PSUM_BW-1:0] out_data,
  output logic [SEL_BW-1:0]         out_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      drain_done,
  output logic                      ovf_flag
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic signed [ACC_BW-1:0] OUT_MAX =
    {{(ACC_BW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] OUT_MIN =
    {{(ACC_BW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
  localparam logic [SEL_BW-1:0] LAST_IDX = SEL_BW'(NUM_LINES - 1);

  state_t                    r_state;
  logic signed [ACC_BW-1:0]  r_acc [NUM_LINES];
  logic [SEL_BW-1:0]         r_ptr;
  logic                      r_out_valid;
  logic                      r_drain_done;
  logic                      r_ovf;

  logic                      w_accept;
  logic                      w_line_ok;
  logic signed [ACC_BW-1:0]  w_cur;
  logic signed [ACC_BW:0]    w_sum;
  logic                      w_sat;
  logic signed [ACC_BW-1:0]  w_new;
  logic                      w_ovf_hit;
  logic signed [ACC_BW-1:0]  w_drain_raw;
  logic signed [PSUM_BW-1:0] w_clamped;

  assign w_accept  = psum_valid && (r_state == S_IDLE);
  assign w_line_ok = (int'(selLine) < NUM_LINES);

  // Entry reads go through a compare loop so an out-of-range select never
  // indexes past the array.
  always_comb begin
    w_cur       = '0;
    w_drain_raw = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (selLine == SEL_BW'(i)) w_cur = r_acc[i];
      if (r_ptr == SEL_BW'(i))   w_drain_raw = r_acc[i];
    end
  end

  // One extra bit of headroom: the top two bits disagree exactly when the
  // true sum is outside the ACC_BW range.
  assign w_sum = (ACC_BW+1)'(w_cur) + (ACC_BW+1)'(psum_in);
  assign w_sat = w_sum[ACC_BW] ^ w_sum[ACC_BW-1];

  always_comb begin
    w_new = ACC_BW'(psum_in);
    if (acc) begin
      if (w_sat) w_new = w_sum[ACC_BW] ? ACC_MIN : ACC_MAX;
      else       w_new = w_sum[ACC_BW-1:0];
    end
  end

  assign w_ovf_hit = w_accept && w_line_ok && acc && w_sat;

  always_comb begin
    if (w_drain_raw > OUT_MAX)      w_clamped = {1'b0, {(PSUM_BW-1){1'b1}}};
    else if (w_drain_raw < OUT_MIN) w_clamped = {1'b1, {(PSUM_BW-1){1'b0}}};
    else                            w_clamped = w_drain_raw[PSUM_BW-1:0];
    if (relu && w_clamped[PSUM_BW-1]) w_clamped = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_out_valid  <= 1'b0;
      r_drain_done <= 1'b0;
      r_ovf        <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) r_acc[i] <= '0;
    end else begin
      r_drain_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_line_ok) begin
            for (int i = 0; i < NUM_LINES; i++)
              if (selLine == SEL_BW'(i)) r_acc[i] <= w_new;
          end
          if (drain_start) begin
            // A coincident psum lands in the same edge, so the drain sees it;
            // its own saturation survives the flag clear.
            r_state     <= S_DRAIN;
            r_ptr       <= '0;
            r_out_valid <= 1'b1;
            r_ovf       <= w_ovf_hit;
          end else if (w_ovf_hit) begin
            r_ovf <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            for (int i = 0; i < NUM_LINES; i++)
              if (r_ptr == SEL_BW'(i)) r_acc[i] <= '0;
            if (r_ptr == LAST_IDX) begin
              r_state      <= S_IDLE;
              r_ptr        <= '0;
              r_out_valid  <= 1'b0;
              r_drain_done <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign psum_ready = (r_state == S_IDLE);
  assign out_idx    = r_ptr;
  assign out_valid  = r_out_valid;
  assign out_data   = w_clamped;
  assign drain_done = r_drain_done;
  assign ovf_flag   = r_ovf;

endmodule

// File: tb/tb_sfu_acc_bank.sv
// tb/tb_sfu_acc_bank.sv - directed self-checking bench for sfu_acc_bank
module tb_sfu_acc_bank;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] psum_in;
  logic               psum_valid;
  logic               psum_ready;
  logic [3:0]         selLine;
  logic               acc;
  logic               relu;
  logic               drain_start;
  logic signed [15:0] out_data;
  logic [3:0]         out_idx;
  logic               out_valid;
  logic               out_ready;
  logic               drain_done;
  logic               ovf_flag;

  int   vectors    = 0;
  int   miscompares = 0;
  int   ev [16];
  logic exp_ovf;

  always #5 clk = ~clk;

  sfu_acc_bank #(
    .PSUM_BW(16), .NUM_LINES(16), .SEL_BW(4), .ACC_BW(24)
  ) dut (
    .clk(clk), .reset(reset),
    .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .selLine(selLine), .acc(acc), .relu(relu), .drain_start(drain_start),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .drain_done(drain_done), .ovf_flag(ovf_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 16; i++) ev[i] = 0;
  endtask

  task automatic push(input logic [3:0] line, input logic signed [15:0] val, input logic a);
    psum_valid = 1'b1;
    selLine    = line;
    psum_in    = val;
    acc        = a;
    tick();
    psum_valid = 1'b0;
  endtask

  // Full drain against ev[]; optional stall at one index, optional psum and
  // drain_start noise during the drain, optional psum coincident with start.
  task automatic drain(input logic relu_v, input int stall_idx, input logic noise,
                       input logic co_v, input logic [3:0] co_line,
                       input logic signed [15:0] co_val);
    relu        = relu_v;
    drain_start = 1'b1;
    psum_valid  = co_v;
    selLine     = co_line;
    psum_in     = co_val;
    acc         = 1'b1;
    tick();
    drain_start = noise;
    psum_valid  = noise;
    selLine     = 4'd1;
    psum_in     = 16'sd5;
    out_ready   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_idx", 32'(out_idx), i);
      check("beat_data", 32'(out_data), ev[i]);
      check("beat_no_done", 32'(drain_done), 32'd0);
      check("beat_ready_low", 32'(psum_ready), 32'd0);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_idx", 32'(out_idx), i);
          check("stall_data", 32'(out_data), ev[i]);
          check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    drain_start = 1'b0;
    psum_valid  = 1'b0;
    check("end_valid", 32'(out_valid), 32'd0);
    check("end_done", 32'(drain_done), 32'd1);
    check("end_ready", 32'(psum_ready), 32'd1);
    check("end_ovf", 32'(ovf_flag), 32'(exp_ovf));
    tick();
    check("done_pulse_len", 32'(drain_done), 32'd0);
  endtask

  initial begin
    reset = 1'b0; psum_in = '0; psum_valid = 1'b0; selLine = '0; acc = 1'b0;
    relu = 1'b0; drain_start = 1'b0; out_ready = 1'b0;

    // Reset, with a competing psum and drain_start that must lose.
    reset = 1'b1; psum_valid = 1'b1; selLine = 4'd2; psum_in = 16'sd9;
    acc = 1'b1; drain_start = 1'b1;
    tick();
    reset = 1'b0; psum_valid = 1'b0; drain_start = 1'b0;
    check("rst_ready", 32'(psum_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(ovf_flag), 32'd0);
    check("rst_done", 32'(drain_done), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    clear_ev(); exp_ovf = 1'b0;
    drain(1'b0, -1, 1'b0, 1'b0, 4'd0, 16'sd0);

    // Accumulate.
    push(4'd3, 16'sd5, 1'b1);
    push(4'd3, 16'sd6, 1'b1);
    push(4'd4, 16'sd7, 1'b1);
    clear_ev(); ev[3] = 11; ev[4] = 7;
    drain(1'b0, -1, 1'b0, 1'b0, 4'd0, 16'sd0);

    // Overwrite, then ReLU; second drain carries ignored psum/drain_start noise.
    push(4'd0, 16'sd100, 1'b1);
    push(4'd0, -16'sd7, 1'b0);
    clear_ev(); ev[0] = -7;
    drain(1'b0, -1, 1'b0, 1'b0, 4'd0, 16'sd0);
    push(4'd0, 16'sd100, 1'b1);
    push(4'd0, -16'sd7, 1'b0);
    push(4'd3, 16'sd11, 1'b1);
    clear_ev(); ev[3] = 11;
    drain(1'b1, -1, 1'b1, 1'b0, 4'd0, 16'sd0);

    // Output clamp without accumulator saturation.
    push(4'd6, 16'sd20000, 1'b1);
    push(4'd6, 16'sd20000, 1'b1);
    check("line6_no_ovf", 32'(ovf_flag), 32'd0);
    clear_ev(); ev[6] = 32767;
    drain(1'b0, -1, 1'b0, 1'b0, 4'd0, 16'sd0);

    // Accumulator saturation; drain_start clears the flag.
    for (int k = 0; k < 300; k++) push(4'd5, 16'sd32767, 1'b1);
    check("sat_ovf", 32'(ovf_flag), 32'd1);
    clear_ev(); ev[5] = 32767; exp_ovf = 1'b0;
    drain(1'b0, -1, 1'b0, 1'b0, 4'd0, 16'sd0);

    // 256 x 32767 = 8388352 fits; the coincident +32767 saturates.
    for (int k = 0; k < 256; k++) push(4'd5, 16'sd32767, 1'b1);
    check("near_sat_no_ovf", 32'(ovf_flag), 32'd0);
    clear_ev(); ev[5] = 32767; exp_ovf = 1'b1;
    drain(1'b0, -1, 1'b0, 1'b1, 4'd5, 16'sd32767);

    // Backpressure at idx 2 plus a non-saturating coincident psum.
    push(4'd2, 16'sd42, 1'b1);
    clear_ev(); ev[2] = 42; ev[9] = 3; exp_ovf = 1'b0;
    drain(1'b0, 2, 1'b0, 1'b1, 4'd9, 16'sd3);

    // Reset in the middle of a drain.
    push(4'd10, 16'sd77, 1'b1);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    out_ready   = 1'b1;
    repeat (7) tick();
    check("mid_idx", 32'(out_idx), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(psum_ready), 32'd1);
    check("mid_rst_done", 32'(drain_done), 32'd0);
    check("mid_rst_idx", 32'(out_idx), 32'd0);
    tick();
    check("mid_rst_done2", 32'(drain_done), 32'd0);
    clear_ev(); exp_ovf = 1'b0;
    drain(1'b0, -1, 1'b0, 1'b0, 4'd0, 16'sd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
